// File: rtl/iter_div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and
// handshake level constants.
package iter_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/iter_div.sv
// Iterative restoring divider, signed or unsigned, one quotient bit per cycle.
// Result is {remainder, quotient}; signs are restored when entering END.
module iter_div
    import iter_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_sign_div_input,
    input  logic [WIDTH-1:0]     div_data1_input,
    input  logic [WIDTH-1:0]     div_data2_input,
    input  logic                 div_start_input,
    input  logic                 div_cancel_input,
    output logic [2*WIDTH-1:0]   div_result_output,
    output logic                 div_ready_output,
    output logic                 div_busy_output,
    output logic                 div_by_zero_output
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 dbz_q, dbz_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       trial, diff;
    logic [WIDTH-1:0]     rem_n, quo_n;
    logic [WIDTH-1:0]     rem_fin, quo_fin;

    always_comb begin
        // Operand magnitudes; -2^(WIDTH-1) negates to itself, read as unsigned.
        a_neg = is_sign_div_input & div_data1_input[WIDTH-1];
        b_neg = is_sign_div_input & div_data2_input[WIDTH-1];
        a_mag = a_neg ? ('0 - div_data1_input) : div_data1_input;
        b_mag = b_neg ? ('0 - div_data2_input) : div_data2_input;

        // Partial remainder carries one extra bit so divisors up to 2^WIDTH-1 work.
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
        quo_fin = neg_quo_q ? ('0 - quo_n) : quo_n;
        rem_fin = neg_rem_q ? ('0 - rem_n) : rem_n;

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        dbz_d     = dbz_q;

        unique case (state_q)
            DIV_IDLE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                dbz_d    = 1'b0;
                if (div_start_input == DIV_START) begin
                    if (div_data2_input == '0) begin
                        state_d = DIV_ZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = a_mag;
                        dvs_d     = b_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
            end
            DIV_ZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
                dbz_d    = 1'b1;
            end
            DIV_ON: begin
                rem_d = rem_n;
                quo_d = quo_n;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DIV_END;
                    result_d = {rem_fin, quo_fin};
                    ready_d  = DIV_RESULT_READY;
                    dbz_d    = 1'b0;
                end
            end
            DIV_END: begin
                if (div_start_input == DIV_STOP) begin
                    state_d  = DIV_IDLE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    dbz_d    = 1'b0;
                end
            end
            default: state_d = DIV_IDLE;
        endcase

        if (div_cancel_input) begin
            state_d  = DIV_IDLE;
            cnt_d    = '0;
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
            dbz_d    = 1'b0;
        end

        busy_d = (state_d == DIV_ZERO) || (state_d == DIV_ON);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
            busy_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            dbz_q     <= dbz_d;
        end
    end

    assign div_result_output  = result_q;
    assign div_ready_output   = ready_q;
    assign div_busy_output    = busy_q;
    assign div_by_zero_output = dbz_q;

endmodule

// File: tb/tb_iter_div.sv
// Directed self-checking bench for iter_div: WIDTH=32 main instance plus a
// WIDTH=8 instance for the narrow-operand case.
module tb_iter_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        sgn = 1'b0;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [63:0] result;
    logic        ready, busy, dbz;

    logic        s8_start = 1'b0;
    logic [7:0]  s8_d1 = '0;
    logic [7:0]  s8_d2 = '0;
    logic [15:0] s8_result;
    logic        s8_ready, s8_busy, s8_dbz;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    iter_div #(.WIDTH(32)) dut (
        .clock              (clk),
        .reset              (rst_n),
        .is_sign_div_input  (sgn),
        .div_data1_input    (d1),
        .div_data2_input    (d2),
        .div_start_input    (start),
        .div_cancel_input   (cancel),
        .div_result_output  (result),
        .div_ready_output   (ready),
        .div_busy_output    (busy),
        .div_by_zero_output (dbz)
    );

    iter_div #(.WIDTH(8)) dut8 (
        .clock              (clk),
        .reset              (rst_n),
        .is_sign_div_input  (1'b0),
        .div_data1_input    (s8_d1),
        .div_data2_input    (s8_d2),
        .div_start_input    (s8_start),
        .div_cancel_input   (1'b0),
        .div_result_output  (s8_result),
        .div_ready_output   (s8_ready),
        .div_busy_output    (s8_busy),
        .div_by_zero_output (s8_dbz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; operands are scrambled after acceptance to show they are ignored.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int exp_edges,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dbz, input int hold);
        int edges = 0;
        @(negedge clk);
        sgn = s; d1 = a; d2 = b; start = 1'b1;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                check({tag, "_busy"}, 64'(busy), 64'd1);
                d1 = ~a; d2 = b ^ 32'h5A5A_0001; sgn = ~s;
            end
            if (ready) break;
        end
        check({tag, "_edges"}, 64'(edges), 64'(exp_edges));
        check({tag, "_result"}, result, {exp_r, exp_q});
        check({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_rdy"}, 64'(ready), 64'd1);
            check({tag, "_hold_res"}, result, {exp_r, exp_q});
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop_rdy"}, 64'(ready), 64'd0);
        check({tag, "_drop_res"}, result, 64'd0);
    endtask

    initial begin
        int rdy_seen;
        int e8;

        #2 rst_n = 1'b0;
        #1;
        check("rst_result", result, 64'd0);
        check("rst_flags", {61'd0, ready, busy, dbz}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u100_7",   1'b0, 32'd100,       32'd7,         33, 32'h0000_000E, 32'h0000_0002, 1'b0, 5);
        run_op("s-7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 0);
        run_op("s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'h0000_000E, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("dz",       1'b0, 32'h0000_1234, 32'd0,         2,  32'd0,         32'd0,         1'b1, 1);
        run_op("s_minneg", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0,         1'b0, 0);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         33, 32'hFFFF_FFFF, 32'd0,         1'b0, 0);
        run_op("u_big_dv", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000, 1'b0, 0);
        run_op("u5_9",     1'b0, 32'd5,         32'd9,         33, 32'd0,         32'd5,         1'b0, 0);

        // Cancel mid-operation.
        @(negedge clk);
        sgn = 1'b0; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_rdy", 64'(ready), 64'd0);
        check("cancel_res", result, 64'd0);
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) rdy_seen++;
        end
        check("cancel_no_rdy", 64'(rdy_seen), 64'd0);

        // Cancel wins over a simultaneous start in IDLE.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        check("cancel_vs_start", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;

        // Asynchronous reset mid-operation.
        @(negedge clk);
        d1 = 32'd100; d2 = 32'd7; start = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_rdy", 64'(ready), 64'd0);
        check("arst_res", result, 64'd0);
        check("arst_dbz", 64'(dbz), 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) rdy_seen++;
        end
        check("arst_no_rdy", 64'(rdy_seen), 64'd0);

        // Narrow instance: 200 / 3.
        @(negedge clk);
        s8_d1 = 8'd200; s8_d2 = 8'd3; s8_start = 1'b1;
        e8 = 0;
        while (e8 < 50) begin
            @(posedge clk); #1;
            e8++;
            if (s8_ready) break;
        end
        check("w8_edges", 64'(e8), 64'd9);
        check("w8_result", 64'(s8_result), 64'h0242);
        check("w8_dbz", 64'(s8_dbz), 64'd0);
        @(negedge clk);
        s8_start = 1'b0;
        @(posedge clk); #1;
        check("w8_drop", 64'(s8_ready), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
